// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller:
// cause codes, flag bit positions, CP0 addresses and FSM encoding.
package exception_ctrl_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'hA;
    localparam logic [31:0] EXC_OV   = 32'hC;
    localparam logic [31:0] EXC_TR   = 32'hD;
    localparam logic [31:0] EXC_ERET = 32'hE;

    localparam int FL_ADEL_F = 0;
    localparam int FL_RI     = 1;
    localparam int FL_SYS    = 2;
    localparam int FL_BP     = 3;
    localparam int FL_OV     = 4;
    localparam int FL_ADEL_L = 5;
    localparam int FL_ADES   = 6;
    localparam int FL_TR     = 7;
    localparam int FL_ERET   = 8;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BA_NONE = 2'd0,
        BA_PC   = 2'd1,
        BA_MEM  = 2'd2
    } ba_sel_t;

endpackage

// File: rtl/exception_ctrl_if.sv
// Signal bundle between the MEM stage / CP0 and the exception controller.
interface exception_ctrl_if;
    logic        stall_i;
    logic        valid_i;
    logic [8:0]  exc_flags_i;
    logic [31:0] pc_i;
    logic        is_in_delayslot_i;
    logic [31:0] mem_addr_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] newpc_o;
    logic        busy_o;

    modport slave (
        input  stall_i, valid_i, exc_flags_i, pc_i, is_in_delayslot_i,
        input  mem_addr_i, status_i, cause_i, epc_i,
        input  cp0_we_i, cp0_waddr_i, cp0_wdata_i,
        output excepttype_o, current_inst_addr_o, is_in_delayslot_o,
        output bad_addr_o, flush_o, newpc_o, busy_o
    );

    modport master (
        output stall_i, valid_i, exc_flags_i, pc_i, is_in_delayslot_i,
        output mem_addr_i, status_i, cause_i, epc_i,
        output cp0_we_i, cp0_waddr_i, cp0_wdata_i,
        input  excepttype_o, current_inst_addr_o, is_in_delayslot_o,
        input  bad_addr_o, flush_o, newpc_o, busy_o
    );
endinterface

// File: rtl/exception_ctrl_prio_enc.sv
// Priority encoder: picks the single highest-priority event and
// selects which address (if any) becomes BadVAddr.
module exc_prio_enc
    import exception_ctrl_pkg::*;
(
    input  logic        valid_i,
    input  logic        int_pending_i,
    input  logic [8:0]  flags_i,
    output logic [31:0] code_o,
    output ba_sel_t     ba_sel_o
);

    always_comb begin
        code_o   = EXC_NONE;
        ba_sel_o = BA_NONE;
        if (valid_i) begin
            priority case (1'b1)
                int_pending_i:      code_o = EXC_INT;
                flags_i[FL_ADEL_F]: begin
                    code_o   = EXC_ADEL;
                    ba_sel_o = BA_PC;
                end
                flags_i[FL_RI]:     code_o = EXC_RI;
                flags_i[FL_SYS]:    code_o = EXC_SYS;
                flags_i[FL_BP]:     code_o = EXC_BP;
                flags_i[FL_OV]:     code_o = EXC_OV;
                flags_i[FL_TR]:     code_o = EXC_TR;
                flags_i[FL_ADEL_L]: begin
                    code_o   = EXC_ADEL;
                    ba_sel_o = BA_MEM;
                end
                flags_i[FL_ADES]:   begin
                    code_o   = EXC_ADES;
                    ba_sel_o = BA_MEM;
                end
                flags_i[FL_ERET]:   code_o = EXC_ERET;
                default:            code_o = EXC_NONE;
            endcase
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception/interrupt controller: forwards in-flight MTC0 data,
// holds events raised under stall, and sequences the two-cycle flush.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic             clk,
    input  logic             rst,
    exception_ctrl_if.slave  bus
);

    state_t      state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic        ds_q, ds_d;
    logic [31:0] bad_q, bad_d;
    logic [31:0] newpc_q, newpc_d;

    logic [31:0] status_eff, epc_eff;
    logic        int_pending;
    logic [31:0] det_code;
    ba_sel_t     det_ba;
    logic [31:0] det_bad, det_newpc;
    logic        det_evt;
    logic        unused_bits;

    always_comb begin
        status_eff = bus.status_i;
        epc_eff    = bus.epc_i;
        if (bus.cp0_we_i && bus.cp0_waddr_i == CP0_STATUS)
            status_eff = bus.cp0_wdata_i;
        if (bus.cp0_we_i && bus.cp0_waddr_i == CP0_EPC)
            epc_eff = bus.cp0_wdata_i;
    end

    assign int_pending = status_eff[0] & ~status_eff[1]
                       & (|(bus.cause_i[15:8] & status_eff[15:8]));
    assign unused_bits = ^{bus.cause_i[31:16], bus.cause_i[7:0],
                           status_eff[31:16], status_eff[7:2]};

    exc_prio_enc u_enc (
        .valid_i       (bus.valid_i),
        .int_pending_i (int_pending),
        .flags_i       (bus.exc_flags_i),
        .code_o        (det_code),
        .ba_sel_o      (det_ba)
    );

    always_comb begin
        unique case (det_ba)
            BA_PC:   det_bad = bus.pc_i;
            BA_MEM:  det_bad = bus.mem_addr_i;
            default: det_bad = 32'h0;
        endcase
    end

    assign det_newpc = (det_code == EXC_ERET) ? epc_eff : EXC_VECTOR;
    assign det_evt   = (det_code != EXC_NONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            pc_q    <= '0;
            ds_q    <= 1'b0;
            bad_q   <= '0;
            newpc_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            ds_q    <= ds_d;
            bad_q   <= bad_d;
            newpc_q <= newpc_d;
        end
    end

    // Only IDLE evaluates detection, so FLUSH never re-triggers.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pc_d    = pc_q;
        ds_d    = ds_q;
        bad_d   = bad_q;
        newpc_d = newpc_q;
        unique case (state_q)
            S_IDLE: begin
                if (det_evt && !bus.stall_i) begin
                    state_d = S_FLUSH;
                end else if (det_evt) begin
                    state_d = S_HOLD;
                    code_d  = det_code;
                    pc_d    = bus.pc_i;
                    ds_d    = bus.is_in_delayslot_i;
                    bad_d   = det_bad;
                    newpc_d = det_newpc;
                end
            end
            S_HOLD:  if (!bus.stall_i) state_d = S_FLUSH;
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.excepttype_o        = '0;
        bus.current_inst_addr_o = '0;
        bus.is_in_delayslot_o   = 1'b0;
        bus.bad_addr_o          = '0;
        bus.flush_o             = 1'b0;
        bus.newpc_o             = '0;
        bus.busy_o              = (state_q != S_IDLE);
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (det_evt && !bus.stall_i) begin
                        bus.excepttype_o        = det_code;
                        bus.current_inst_addr_o = bus.pc_i;
                        bus.is_in_delayslot_o   = bus.is_in_delayslot_i;
                        bus.bad_addr_o          = det_bad;
                        bus.flush_o             = 1'b1;
                        bus.newpc_o             = det_newpc;
                    end
                end
                S_HOLD: begin
                    if (!bus.stall_i) begin
                        bus.excepttype_o        = code_q;
                        bus.current_inst_addr_o = pc_q;
                        bus.is_in_delayslot_o   = ds_q;
                        bus.bad_addr_o          = bad_q;
                        bus.flush_o             = 1'b1;
                        bus.newpc_o             = newpc_q;
                    end
                end
                S_FLUSH: bus.flush_o = 1'b1;
                default: bus.flush_o = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Scoreboard bench for exception_ctrl: directed vectors push expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_exception_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    typedef struct {
        logic [31:0] code;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bad;
        logic        flush;
        logic [31:0] newpc;
        logic        busy;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];

    exception_ctrl_if bus ();

    exception_ctrl #(.EXC_VECTOR(VEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(logic [31:0] code, logic [31:0] pc,
                                logic ds, logic [31:0] bad, logic flush,
                                logic [31:0] newpc, logic busy);
        exp_t e;
        e.code = code; e.pc = pc; e.ds = ds; e.bad = bad;
        e.flush = flush; e.newpc = newpc; e.busy = busy;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("excepttype", bus.excepttype_o, e.code);
                chk("inst_addr", bus.current_inst_addr_o, e.pc);
                chk("delayslot", {31'b0, bus.is_in_delayslot_o}, {31'b0, e.ds});
                chk("bad_addr", bus.bad_addr_o, e.bad);
                chk("flush", {31'b0, bus.flush_o}, {31'b0, e.flush});
                chk("busy", {31'b0, bus.busy_o}, {31'b0, e.busy});
                if (e.code != 32'h0) chk("newpc", bus.newpc_o, e.newpc);
            end
        end
    end

    task automatic clr();
        bus.stall_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.exc_flags_i = '0;
        bus.pc_i = '0;
        bus.is_in_delayslot_i = 1'b0;
        bus.mem_addr_i = '0;
        bus.status_i = '0;
        bus.cause_i = '0;
        bus.epc_i = '0;
        bus.cp0_we_i = 1'b0;
        bus.cp0_waddr_i = '0;
        bus.cp0_wdata_i = '0;
    endtask

    task automatic step(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t z, fl;
        z  = mk(0, 0, 0, 0, 0, 0, 0);
        fl = mk(0, 0, 0, 0, 1, 0, 1);
        clr();
        @(posedge clk); #1;
        step(z);
        rst = 1'b0;
        step(z);

        // SYSCALL, held in MEM through the flush cycle
        bus.valid_i = 1'b1; bus.exc_flags_i[2] = 1'b1;
        bus.pc_i = 32'hBFC00100;
        step(mk(32'h8, 32'hBFC00100, 0, 0, 1, VEC, 0));
        step(fl);
        clr();
        step(z);

        // load AdEL + RI together, RI wins; delay slot passed through
        bus.valid_i = 1'b1; bus.exc_flags_i = 9'b0_0010_0010;
        bus.mem_addr_i = 32'h80000003; bus.pc_i = 32'h80001000;
        bus.is_in_delayslot_i = 1'b1;
        step(mk(32'hA, 32'h80001000, 1, 0, 1, VEC, 0));
        clr();
        step(fl);
        step(z);

        // load AdEL under a 3-cycle stall
        bus.valid_i = 1'b1; bus.exc_flags_i[5] = 1'b1;
        bus.mem_addr_i = 32'h80000003; bus.pc_i = 32'h80001004;
        bus.stall_i = 1'b1;
        step(z);
        bus.exc_flags_i = 9'b0_0000_0100; bus.pc_i = 32'h1234;
        step(mk(0, 0, 0, 0, 0, 0, 1));
        step(mk(0, 0, 0, 0, 0, 0, 1));
        clr();
        step(mk(32'h4, 32'h80001004, 0, 32'h80000003, 1, VEC, 1));
        step(fl);
        step(z);

        // ERET with EPC forwarded from an MTC0 in WB
        bus.valid_i = 1'b1; bus.exc_flags_i[8] = 1'b1; bus.pc_i = 32'h300;
        bus.epc_i = 32'h100; bus.cp0_we_i = 1'b1;
        bus.cp0_waddr_i = 5'd14; bus.cp0_wdata_i = 32'h200;
        step(mk(32'hE, 32'h300, 0, 0, 1, 32'h200, 0));
        clr();
        step(fl);
        step(z);

        // pending interrupt but MEM holds a bubble
        bus.status_i = 32'h0000FF01; bus.cause_i = 32'h400;
        step(z);

        // interrupt beats overflow
        bus.valid_i = 1'b1; bus.exc_flags_i[4] = 1'b1; bus.pc_i = 32'h400;
        step(mk(32'h1, 32'h400, 0, 0, 1, VEC, 0));
        clr();
        step(fl);
        step(z);

        // EXL set masks the interrupt
        bus.status_i = 32'h0000FF03; bus.cause_i = 32'h400;
        bus.valid_i = 1'b1; bus.exc_flags_i[4] = 1'b1; bus.pc_i = 32'h404;
        step(mk(32'hC, 32'h404, 0, 0, 1, VEC, 0));
        clr();
        step(fl);
        step(z);

        // reset while holding a BREAK
        bus.valid_i = 1'b1; bus.exc_flags_i[3] = 1'b1; bus.pc_i = 32'h500;
        bus.stall_i = 1'b1;
        step(z);
        step(mk(0, 0, 0, 0, 0, 0, 1));
        #2 rst = 1'b1;
        sb.push_back(z);
        @(posedge clk); #1;
        clr();
        rst = 1'b0;
        step(z);
        step(z);
        step(z);

        @(negedge clk);
        if (sb.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d left want 0", sb.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
